// File: rtl/dsu_host_interface_pkg.sv
// Shared types for the DSU host front end: opcodes, FSM states,
// status-word bit positions and response error codes.
`ifndef THREAD_NUMB
`define THREAD_NUMB 4
`endif

package dsu_host_interface_pkg;

  localparam int THREAD_NUMB = `THREAD_NUMB;
  localparam int TID_W =
    (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1;

  typedef logic [TID_W-1:0] thread_id_t;

  typedef enum logic [3:0] {
    OP_NOP         = 4'd0,
    OP_SET_ENABLE  = 4'd1,
    OP_SET_STEP    = 4'd2,
    OP_SET_BP      = 4'd3,
    OP_SET_BP_EN   = 4'd4,
    OP_SET_THREAD  = 4'd5,
    OP_RESUME      = 4'd6,
    OP_READ_STATUS = 4'd7,
    OP_READ_BP_PC  = 4'd8
  } dsu_cmd_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESPOND,
    S_WAIT_UNFREEZE
  } dsu_state_t;

  localparam int ST_FREEZE = 0;
  localparam int ST_HIT    = 1;
  localparam int ST_ENABLE = 2;
  localparam int ST_STEP   = 3;
  localparam int ST_SEL    = 4;
  localparam int ST_TID_LO = 8;
  localparam int ST_MSK_LO = 16;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

  function automatic logic [31:0] status_word(
    input logic        freeze,
    input logic        hit,
    input logic        en,
    input logic        step,
    input logic        sel,
    input logic [7:0]  tid,
    input logic [15:0] mask
  );
    logic [31:0] w;
    w = '0;
    w[ST_FREEZE] = freeze;
    w[ST_HIT]    = hit;
    w[ST_ENABLE] = en;
    w[ST_STEP]   = step;
    w[ST_SEL]    = sel;
    w[ST_TID_LO +: 8]  = tid;
    w[ST_MSK_LO +: 16] = mask;
    return w;
  endfunction

endpackage

// File: rtl/dsu_host_interface_timer.sv
// Resume watchdog: loaded on RESUME, counts down while waiting
// for freeze to drop; o_expire flags the final counting cycle.
module dsu_host_interface_timer #(
  parameter int RESUME_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam int CW = $clog2(RESUME_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(RESUME_TIMEOUT);
    end else if (i_dec && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == CW'(1));

endmodule

// File: rtl/dsu_host_interface.sv
// Host command/response front end for the DSU config registers.
// Define DSU_HOST_IRQ_EN to enable the sticky breakpoint host_irq.
module dsu_host_interface
  import dsu_host_interface_pkg::*;
#(
  parameter int BP_NUMB        = 8,
  parameter int RESUME_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic [3:0]        host_cmd_op,
  input  logic [7:0]        host_cmd_idx,
  input  logic [31:0]       host_cmd_data,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic              host_rsp_err,
  output logic [31:0]       host_rsp_data,
  output logic              host_irq,
  input  logic              freeze,
  input  logic              dsu_hit_breakpoint,
  input  thread_id_t        dsu_bp_thread_id,
  input  logic [31:0]       dsu_bp_instruction [THREAD_NUMB],
  output logic              dsu_enable,
  output logic              dsu_single_step,
  output logic [31:0]       dsu_breakpoint [BP_NUMB],
  output logic [BP_NUMB-1:0] dsu_breakpoint_enable,
  output logic              dsu_thread_selection,
  output thread_id_t        dsu_thread_id,
  output logic              resume
);

  localparam int BW = (BP_NUMB > 1) ? $clog2(BP_NUMB) : 1;

  dsu_state_t   r_state;
  dsu_state_t   w_state_n;
  logic         r_rsp_err;
  logic         w_err_n;
  logic [31:0]  r_rsp_data;
  logic [31:0]  w_data_n;
  logic         r_resume;
  logic         w_resume_n;

  logic         r_en;
  logic         r_step;
  logic [31:0]  r_bp [BP_NUMB];
  logic [BP_NUMB-1:0] r_bp_en;
  logic         r_sel;
  thread_id_t   r_tid;

  logic         w_accept;
  logic         w_bp_ok;
  logic         w_tid_ok;
  logic [BW-1:0] w_bp_idx;
  thread_id_t   w_tid_idx;
  logic [31:0]  w_status;
  logic [31:0]  w_pc;
  logic         w_load;
  logic         w_dec;
  logic         w_expire;
  logic         w_wr_en;
  logic         w_wr_step;
  logic         w_wr_bp;
  logic         w_wr_bpen;
  logic         w_wr_thr;

  assign w_accept  = (r_state == S_IDLE) && host_cmd_valid;
  assign w_bp_ok   = {24'd0, host_cmd_idx} < 32'(BP_NUMB);
  assign w_tid_ok  = {24'd0, host_cmd_idx} < 32'(THREAD_NUMB);
  assign w_bp_idx  = host_cmd_idx[BW-1:0];
  assign w_tid_idx = host_cmd_idx[TID_W-1:0];
  assign w_pc      = dsu_bp_instruction[w_tid_idx];

  assign w_status = status_word(freeze, dsu_hit_breakpoint,
                                r_en, r_step, r_sel,
                                8'(dsu_bp_thread_id),
                                16'(r_bp_en));

  dsu_host_interface_timer #(
    .RESUME_TIMEOUT(RESUME_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .o_expire(w_expire)
  );

  always_comb begin
    w_state_n  = r_state;
    w_err_n    = r_rsp_err;
    w_data_n   = r_rsp_data;
    w_resume_n = 1'b0;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_step  = 1'b0;
    w_wr_bp    = 1'b0;
    w_wr_bpen  = 1'b0;
    w_wr_thr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (host_cmd_valid) begin
          w_state_n = S_RESPOND;
          w_err_n   = ERR_NONE;
          w_data_n  = '0;
          case (host_cmd_op)
            OP_NOP:        ;
            OP_SET_ENABLE: w_wr_en   = 1'b1;
            OP_SET_STEP:   w_wr_step = 1'b1;
            OP_SET_BP_EN:  w_wr_bpen = 1'b1;
            OP_SET_BP: begin
              if (w_bp_ok) w_wr_bp = 1'b1;
              else         w_err_n = ERR_FAIL;
            end
            OP_SET_THREAD: begin
              if (w_tid_ok) w_wr_thr = 1'b1;
              else          w_err_n  = ERR_FAIL;
            end
            OP_RESUME: begin
              if (freeze) begin
                w_state_n  = S_WAIT_UNFREEZE;
                w_resume_n = 1'b1;
                w_load     = 1'b1;
              end else begin
                w_err_n = ERR_FAIL;
              end
            end
            OP_READ_STATUS: w_data_n = w_status;
            OP_READ_BP_PC: begin
              if (w_tid_ok) w_data_n = w_pc;
              else          w_err_n  = ERR_FAIL;
            end
            default: w_err_n = ERR_FAIL;
          endcase
        end
      end
      // freeze dropping beats the watchdog on the same cycle
      S_WAIT_UNFREEZE: begin
        if (!freeze) begin
          w_state_n = S_RESPOND;
          w_err_n   = ERR_NONE;
        end else if (w_expire) begin
          w_state_n = S_RESPOND;
          w_err_n   = ERR_FAIL;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_RESPOND: begin
        if (host_rsp_ready) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
      r_resume   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_rsp_err  <= w_err_n;
      r_rsp_data <= w_data_n;
      r_resume   <= w_resume_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en    <= 1'b0;
      r_step  <= 1'b0;
      r_bp_en <= '0;
      r_sel   <= 1'b0;
      r_tid   <= '0;
      for (int i = 0; i < BP_NUMB; i++) r_bp[i] <= '0;
    end else begin
      if (w_wr_en)   r_en    <= host_cmd_data[0];
      if (w_wr_step) r_step  <= host_cmd_data[0];
      if (w_wr_bpen) r_bp_en <= host_cmd_data[BP_NUMB-1:0];
      if (w_wr_bp)   r_bp[w_bp_idx] <= host_cmd_data;
      if (w_wr_thr) begin
        r_sel <= host_cmd_data[0];
        r_tid <= w_tid_idx;
      end
    end
  end

`ifdef DSU_HOST_IRQ_EN
  logic r_hit_q;
  logic r_irq;
  logic w_clr_irq;

  assign w_clr_irq = w_accept && (host_cmd_op == OP_READ_STATUS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_q <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_hit_q <= dsu_hit_breakpoint;
      if (dsu_hit_breakpoint && !r_hit_q) r_irq <= 1'b1;
      else if (w_clr_irq)                 r_irq <= 1'b0;
    end
  end

  assign host_irq = r_irq;
`else
  assign host_irq = 1'b0;
`endif

  assign host_cmd_ready        = (r_state == S_IDLE);
  assign host_rsp_valid        = (r_state == S_RESPOND);
  assign host_rsp_err          = r_rsp_err;
  assign host_rsp_data         = r_rsp_data;
  assign resume                = r_resume;
  assign dsu_enable            = r_en;
  assign dsu_single_step       = r_step;
  assign dsu_breakpoint        = r_bp;
  assign dsu_breakpoint_enable = r_bp_en;
  assign dsu_thread_selection  = r_sel;
  assign dsu_thread_id         = r_tid;

endmodule
